// File: rtl/pix_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pix_engine_pkg
// Brief    : Shared mode codes, FSM states and 1-2-1 kernel for the pixel engine
// Revision : 1.0
// ============================================================================
package pix_engine_pkg;

  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_INVERT = 2'b01;
  localparam logic [1:0] MODE_FILTER = 2'b10;
  localparam logic [1:0] MODE_THRESH = 2'b11;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Rounded 1-2-1 kernel. Callers pass zero-extended pixels; the result always
  // fits back into the pixel width, so truncating at the call site is lossless.
  function automatic logic [31:0] kernel_121(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [31:0] c);
    return (a + (b << 1) + c + 32'd2) >> 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pix_point_op.sv
`default_nettype none
// ============================================================================
// Module   : pix_point_op
// Brief    : Combinational per-pixel operator for bypass, invert and threshold
// Revision : 1.0
// ============================================================================
module pix_point_op
  import pix_engine_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic [1:0]       i_mode,
  input  logic [PIX_W-1:0] i_pix,
  input  logic [PIX_W-1:0] i_thresh,
  output logic [PIX_W-1:0] o_result
);

  always_comb begin
    o_result = i_pix;
    case (i_mode)
      MODE_INVERT: o_result = ~i_pix;  // bitwise NOT equals (2^W-1) - pix
      MODE_THRESH: o_result = (i_pix >= i_thresh) ? '1 : '0;
      default:     o_result = i_pix;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pixel_stream_engine.sv
`default_nettype none
// ============================================================================
// Module   : pixel_stream_engine
// Brief    : Valid/ready pixel engine with per-line mode latch and 1-2-1 filter
// Revision : 1.0
// ============================================================================
module pixel_stream_engine
  import pix_engine_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int LINE_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_eol,
  input  logic [1:0]       cfg_mode,
  input  logic [PIX_W-1:0] cfg_thresh,
  output logic [CNT_W-1:0] pix_count
);

  localparam int                 c_col_w    = $clog2(LINE_W);
  localparam logic [c_col_w-1:0] c_last_col = c_col_w'(LINE_W - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_col_w-1:0] r_col;
  logic [1:0]         r_act_mode;
  logic [PIX_W-1:0]   r_act_thresh;
  logic [PIX_W-1:0]   r_p_prev;
  logic [PIX_W-1:0]   r_p_cur;
  logic               r_out_valid;
  logic [PIX_W-1:0]   r_out_pixel;
  logic               r_out_eol;
  logic [CNT_W-1:0]   r_pix_count;

  logic               w_out_free;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_deliver;
  logic               w_col_first;
  logic               w_col_last;
  logic [1:0]         w_mode;
  logic [PIX_W-1:0]   w_thresh;
  logic [PIX_W-1:0]   w_point;
  logic [PIX_W-1:0]   w_filt_in;
  logic [PIX_W-1:0]   w_filt_flush;
  logic               w_load;
  logic [PIX_W-1:0]   w_load_pixel;
  logic               w_load_eol;

  assign w_out_free  = !r_out_valid || out_ready;
  assign w_in_ready  = (r_state == ST_RUN) && w_out_free;
  assign w_accept    = in_valid && w_in_ready;
  assign w_deliver   = r_out_valid && out_ready;
  assign w_col_first = (r_col == '0);
  assign w_col_last  = (r_col == c_last_col);

  // The first pixel of a line already uses the configuration it latches.
  assign w_mode   = w_col_first ? cfg_mode   : r_act_mode;
  assign w_thresh = w_col_first ? cfg_thresh : r_act_thresh;

  pix_point_op #(
    .PIX_W (PIX_W)
  ) u_point_op (
    .i_mode   (w_mode),
    .i_pix    (in_pixel),
    .i_thresh (w_thresh),
    .o_result (w_point)
  );

  assign w_filt_in    = PIX_W'(kernel_121(32'(r_p_prev), 32'(r_p_cur), 32'(in_pixel)));
  assign w_filt_flush = PIX_W'(kernel_121(32'(r_p_prev), 32'(r_p_cur), 32'(r_p_cur)));

  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_load_pixel = '0;
    w_load_eol   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_accept) begin
          if (w_mode == MODE_FILTER) begin
            // Column 0 only primes the window; output lags input by one column.
            w_load       = !w_col_first;
            w_load_pixel = w_filt_in;
            if (w_col_last) w_state_nxt = ST_FLUSH;
          end else begin
            w_load       = 1'b1;
            w_load_pixel = w_point;
            w_load_eol   = w_col_last;
          end
        end
      end
      ST_FLUSH: begin
        if (w_out_free) begin
          w_load       = 1'b1;
          w_load_pixel = w_filt_flush;
          w_load_eol   = 1'b1;
          w_state_nxt  = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_RUN;
      r_col        <= '0;
      r_act_mode   <= MODE_BYPASS;
      r_act_thresh <= '0;
      r_p_prev     <= '0;
      r_p_cur      <= '0;
      r_out_valid  <= 1'b0;
      r_out_pixel  <= '0;
      r_out_eol    <= 1'b0;
      r_pix_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_col <= w_col_last ? '0 : r_col + 1'b1;
        if (w_col_first) begin
          r_act_mode   <= cfg_mode;
          r_act_thresh <= cfg_thresh;
        end
        if (w_mode == MODE_FILTER) begin
          r_p_prev <= w_col_first ? in_pixel : r_p_cur;
          r_p_cur  <= in_pixel;
        end
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_pixel <= w_load_pixel;
        r_out_eol   <= w_load_eol;
      end else if (w_deliver) begin
        r_out_valid <= 1'b0;
      end
      if (w_deliver) r_pix_count <= r_pix_count + 1'b1;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_pixel = r_out_pixel;
  assign out_eol   = r_out_eol;
  assign pix_count = r_pix_count;

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_stream_engine
// Brief    : Directed and randomized checks of pixel_stream_engine vs a line model
// Revision : 1.0
// ============================================================================
module tb_pixel_stream_engine;

  localparam int PIX_W  = 8;
  localparam int LINE_W = 4;
  localparam int CNT_W  = 16;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [PIX_W-1:0] in_pixel = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [PIX_W-1:0] out_pixel;
  logic             out_eol;
  logic [1:0]       cfg_mode = 2'b00;
  logic [PIX_W-1:0] cfg_thresh = '0;
  logic [CNT_W-1:0] pix_count;

  always #5 clk = ~clk;

  pixel_stream_engine #(
    .PIX_W  (PIX_W),
    .LINE_W (LINE_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pixel  (out_pixel),
    .out_eol    (out_eol),
    .cfg_mode   (cfg_mode),
    .cfg_thresh (cfg_thresh),
    .pix_count  (pix_count)
  );

  int         vectors = 0;
  int         miscompares = 0;
  int         delivered_exp = 0;
  bit         rnd_done = 1'b0;
  logic [8:0] exp_q[$];
  logic [7:0] got_q[$];

  // Reference model state: one line buffer, configuration captured at column 0
  logic [7:0]  m_line[LINE_W];
  int          m_col = 0;
  logic [1:0]  m_mode = 2'b00;
  logic [7:0]  m_th = '0;
  logic [15:0] m_cnt = '0;

  function automatic logic [7:0] ref_kernel(input int a, input int b, input int c);
    return 8'((a + 2 * b + c + 2) / 4);
  endfunction

  function automatic logic [7:0] ref_point(input logic [1:0] mode, input int p, input int th);
    case (mode)
      2'b01:   return 8'(255 - p);
      2'b11:   return (p >= th) ? 8'hFF : 8'h00;
      default: return 8'(p);
    endcase
  endfunction

  task automatic scoreboard();
    logic [8:0] e;
    int k;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        exp_q.delete();
        m_col = 0;
        m_cnt = '0;
      end else begin
        vectors++;
        if (pix_count !== m_cnt) begin
          miscompares++;
          $display("FAIL sb_pix_count got=%0d want=%0d", pix_count, m_cnt);
        end
        if (out_valid && out_ready) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL sb_unexpected got=%02h want=none", out_pixel);
          end else begin
            e = exp_q.pop_front();
            if ({out_eol, out_pixel} !== e) begin
              miscompares++;
              $display("FAIL sb_pixel got eol=%0b pix=%02h want eol=%0b pix=%02h",
                       out_eol, out_pixel, e[8], e[7:0]);
            end
          end
          got_q.push_back(out_pixel);
          m_cnt++;
        end
        if (in_valid && in_ready) begin
          if (m_col == 0) begin
            m_mode = cfg_mode;
            m_th   = cfg_thresh;
          end
          m_line[m_col] = in_pixel;
          if (m_mode == 2'b10) begin
            // Column j arriving completes the window centred on column j-1.
            if (m_col >= 1) begin
              k = m_col - 1;
              exp_q.push_back({1'b0, ref_kernel(m_line[(k == 0) ? 0 : k - 1], m_line[k], m_line[k + 1])});
            end
            if (m_col == LINE_W - 1)
              exp_q.push_back({1'b1, ref_kernel(m_line[LINE_W - 2], m_line[LINE_W - 1], m_line[LINE_W - 1])});
          end else begin
            exp_q.push_back({(m_col == LINE_W - 1), ref_point(m_mode, in_pixel, m_th)});
          end
          m_col = (m_col + 1) % LINE_W;
        end
      end
    end
  endtask

  task automatic send_pixel(input logic [7:0] p, input int idle);
    bit acc = 1'b0;
    if (idle > 0) begin
      in_valid = 1'b0;
      repeat (idle) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    in_pixel = p;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    vectors++;
    if (!acc) begin
      miscompares++;
      $display("FAIL send_timeout got=no_accept want=accept pix=%02h", p);
    end
  endtask

  task automatic wait_drain();
    bit drained = 1'b0;
    for (int i = 0; i < 200 && !drained; i++) begin
      @(negedge clk);
      drained = (exp_q.size() == 0) && !out_valid;
    end
    vectors++;
    if (!drained) begin
      miscompares++;
      $display("FAIL drain_timeout got=%0d_pending want=0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cfg_mode = 2'b00; cfg_thresh = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
    vectors++; if (out_pixel !== 8'h00) begin miscompares++; $display("FAIL reset_pixel got=%02h want=00", out_pixel); end
    vectors++; if (out_eol !== 1'b0) begin miscompares++; $display("FAIL reset_eol got=%0b want=0", out_eol); end
    vectors++; if (pix_count !== 16'd0) begin miscompares++; $display("FAIL reset_count got=%0d want=0", pix_count); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    resetn = 1'b1;
    delivered_exp = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_bypass();
    logic [7:0] want[4];
    logic [7:0] g;
    want = '{8'h0A, 8'h14, 8'h1E, 8'h28};
    got_q.delete();
    cfg_mode = 2'b00;
    send_pixel(8'h0A, 0);
    vectors++; if (out_valid !== 1'b1 || out_pixel !== 8'h0A) begin
      miscompares++; $display("FAIL bypass_latency got=%0b/%02h want=1/0a", out_valid, out_pixel); end
    send_pixel(8'h14, 0);
    send_pixel(8'h1E, 0);
    vectors++; if (out_eol !== 1'b0) begin miscompares++; $display("FAIL bypass_mid_eol got=%0b want=0", out_eol); end
    send_pixel(8'h28, 0);
    in_valid = 1'b0;
    vectors++; if (out_eol !== 1'b1 || out_pixel !== 8'h28) begin
      miscompares++; $display("FAIL bypass_last got=%0b/%02h want=1/28", out_eol, out_pixel); end
    wait_drain();
    delivered_exp += 4;
    for (int i = 0; i < 4; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      vectors++; if (g !== want[i]) begin miscompares++; $display("FAIL bypass_out[%0d] got=%02h want=%02h", i, g, want[i]); end
    end
    vectors++; if (pix_count !== 16'(delivered_exp)) begin
      miscompares++; $display("FAIL bypass_count got=%0d want=%0d", pix_count, delivered_exp); end
  endtask

  task automatic test_invert();
    logic [7:0] src[4];
    logic [7:0] want[4];
    logic [7:0] g;
    src  = '{8'h00, 8'h3C, 8'hFF, 8'h80};
    want = '{8'hFF, 8'hC3, 8'h00, 8'h7F};
    got_q.delete();
    cfg_mode = 2'b01;
    for (int i = 0; i < 4; i++) send_pixel(src[i], 0);
    in_valid = 1'b0;
    wait_drain();
    delivered_exp += 4;
    for (int i = 0; i < 4; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      vectors++; if (g !== want[i]) begin miscompares++; $display("FAIL invert_out[%0d] got=%02h want=%02h", i, g, want[i]); end
    end
    vectors++; if (pix_count !== 16'(delivered_exp)) begin
      miscompares++; $display("FAIL invert_count got=%0d want=%0d", pix_count, delivered_exp); end
  endtask

  task automatic test_filter();
    logic [7:0] src[4];
    logic [7:0] want[4];
    logic [7:0] g;
    src  = '{8'h08, 8'h10, 8'h18, 8'hC8};
    want = '{8'h0A, 8'h10, 8'h42, 8'h9C};
    got_q.delete();
    cfg_mode = 2'b10;
    for (int i = 0; i < 4; i++) send_pixel(src[i], 0);
    in_valid = 1'b0;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL filter_flush_ready got=%0b want=0", in_ready); end
    @(posedge clk);
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL filter_after_flush_ready got=%0b want=1", in_ready); end
    vectors++; if (out_eol !== 1'b1 || out_pixel !== 8'h9C) begin
      miscompares++; $display("FAIL filter_flush_out got=%0b/%02h want=1/9c", out_eol, out_pixel); end
    wait_drain();
    delivered_exp += 4;
    for (int i = 0; i < 4; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      vectors++; if (g !== want[i]) begin miscompares++; $display("FAIL filter_out[%0d] got=%02h want=%02h", i, g, want[i]); end
    end
    vectors++; if (pix_count !== 16'(delivered_exp)) begin
      miscompares++; $display("FAIL filter_count got=%0d want=%0d", pix_count, delivered_exp); end
  endtask

  task automatic test_thresh();
    logic [7:0] src[4];
    logic [7:0] want[4];
    logic [7:0] g;
    src  = '{8'h7F, 8'h80, 8'h81, 8'h00};
    want = '{8'h00, 8'hFF, 8'hFF, 8'h00};
    got_q.delete();
    cfg_mode = 2'b11;
    cfg_thresh = 8'h80;
    for (int i = 0; i < 4; i++) send_pixel(src[i], 0);
    in_valid = 1'b0;
    wait_drain();
    delivered_exp += 4;
    for (int i = 0; i < 4; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      vectors++; if (g !== want[i]) begin miscompares++; $display("FAIL thresh_out[%0d] got=%02h want=%02h", i, g, want[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] p[4];
    logic [7:0] g;
    for (int i = 0; i < 4; i++) p[i] = 8'($urandom);
    got_q.delete();
    cfg_mode = 2'b00;
    send_pixel(p[0], 0);
    send_pixel(p[1], 0);
    in_pixel = p[2];
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready[%0d] got=%0b want=0", c, in_ready); end
      vectors++; if (out_valid !== 1'b1 || out_pixel !== p[1] || out_eol !== 1'b0) begin
        miscompares++; $display("FAIL bp_hold[%0d] got=%0b/%02h/%0b want=1/%02h/0", c, out_valid, out_pixel, out_eol, p[1]); end
      vectors++; if (pix_count !== 16'(delivered_exp + 1)) begin
        miscompares++; $display("FAIL bp_count[%0d] got=%0d want=%0d", c, pix_count, delivered_exp + 1); end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_pixel(p[2], 0);
    send_pixel(p[3], 0);
    in_valid = 1'b0;
    wait_drain();
    delivered_exp += 4;
    for (int i = 0; i < 4; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      vectors++; if (g !== p[i]) begin miscompares++; $display("FAIL bp_out[%0d] got=%02h want=%02h", i, g, p[i]); end
    end
    vectors++; if (got_q.size() != 4) begin miscompares++; $display("FAIL bp_total got=%0d want=4", got_q.size()); end
    vectors++; if (pix_count !== 16'(delivered_exp)) begin
      miscompares++; $display("FAIL bp_count_end got=%0d want=%0d", pix_count, delivered_exp); end
  endtask

  task automatic test_mode_change();
    logic [7:0] a[4];
    logic [7:0] b[4];
    logic [7:0] g;
    for (int i = 0; i < 4; i++) begin a[i] = 8'($urandom); b[i] = 8'($urandom); end
    got_q.delete();
    cfg_mode = 2'b00;
    for (int i = 0; i < 3; i++) send_pixel(a[i], 0);
    cfg_mode = 2'b01;
    send_pixel(a[3], 0);
    for (int i = 0; i < 4; i++) send_pixel(b[i], 0);
    in_valid = 1'b0;
    wait_drain();
    delivered_exp += 8;
    for (int i = 0; i < 4; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      vectors++; if (g !== a[i]) begin miscompares++; $display("FAIL modechg_old[%0d] got=%02h want=%02h", i, g, a[i]); end
      g = (i + 4 < got_q.size()) ? got_q[i + 4] : 8'hxx;
      vectors++; if (g !== 8'(255 - b[i])) begin
        miscompares++; $display("FAIL modechg_new[%0d] got=%02h want=%02h", i, g, 8'(255 - b[i])); end
    end
  endtask

  task automatic test_reset_in_flush();
    logic [7:0] src[4];
    logic [7:0] want[4];
    logic [7:0] g;
    src  = '{8'h08, 8'h10, 8'h18, 8'hC8};
    want = '{8'h0A, 8'h10, 8'h42, 8'h9C};
    cfg_mode = 2'b10;
    for (int i = 0; i < 4; i++) send_pixel(src[i], 0);
    in_valid = 1'b0;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_flush_entry got=%0b want=0", in_ready); end
    resetn = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0 || out_pixel !== 8'h00 || out_eol !== 1'b0) begin
      miscompares++; $display("FAIL rst_flush_out got=%0b/%02h/%0b want=0/00/0", out_valid, out_pixel, out_eol); end
    vectors++; if (pix_count !== 16'd0) begin miscompares++; $display("FAIL rst_flush_count got=%0d want=0", pix_count); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_flush_ready got=%0b want=1", in_ready); end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    delivered_exp = 0;
    got_q.delete();
    for (int i = 0; i < 4; i++) send_pixel(src[i], 0);
    in_valid = 1'b0;
    wait_drain();
    delivered_exp += 4;
    for (int i = 0; i < 4; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      vectors++; if (g !== want[i]) begin miscompares++; $display("FAIL rst_next_line[%0d] got=%02h want=%02h", i, g, want[i]); end
    end
    vectors++; if (pix_count !== 16'(delivered_exp)) begin
      miscompares++; $display("FAIL rst_next_count got=%0d want=%0d", pix_count, delivered_exp); end
  endtask

  task automatic test_random();
    rnd_done = 1'b0;
    fork
      begin
        for (int l = 0; l < 40; l++) begin
          for (int c = 0; c < LINE_W; c++) begin
            cfg_mode   = 2'($urandom_range(0, 3));
            cfg_thresh = 8'($urandom);
            send_pixel(8'($urandom), int'($urandom_range(0, 2)));
          end
        end
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fork
      scoreboard();
    join_none
    test_reset();
    test_bypass();
    test_invert();
    test_filter();
    test_thresh();
    test_backpressure();
    test_mode_change();
    test_reset_in_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pixel_stream_engine.md
Name: pixel_stream_engine

Overview:
Parametrised next-generation pixel processing engine for the SoC image path. Sits between the sensor-side pixel FIFO and the consumer (DMA/UART readout).
- Adds a valid/ready handshake on both sides.
- Mode is latched per line, so a mid-line mode change never corrupts a line.
- Modes: bypass, invert, threshold, and a real 1-2-1 horizontal smoothing filter with edge replication.
- Counts delivered pixels for software and bench checking.

Parameters:
PIX_W, 8, pixel width in bits.
LINE_W, 16, pixels per line. Must be >= 2.
CNT_W, 16, width of the delivered-pixel counter.

Ports:
clk  in  1  system clock; all logic on rising edge
resetn  in  1  asynchronous active-low reset
in_valid  in  1  input pixel valid
in_ready  out  1  engine can accept input this cycle
in_pixel  in  PIX_W  input pixel
out_valid  out  1  output pixel valid
out_ready  in  1  consumer accepts output
out_pixel  out  PIX_W  processed pixel
out_eol  out  1  qualifies out_pixel as last pixel of line
cfg_mode  in  2  00 bypass, 01 invert, 10 filter 1-2-1, 11 threshold
cfg_thresh  in  PIX_W  threshold for mode 11
pix_count  out  CNT_W  count of output handshakes, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, resetn=0) clears all registers:
  - out_valid=0, out_pixel=0, out_eol=0, pix_count=0.
  - col=0, state=RUN, act_mode=00, act_thresh=0, p_prev=p_cur=0.
- in_ready = (state==RUN) && (!out_valid || out_ready). It is combinational from registered state and out_ready.
- Accept = in_valid && in_ready. Deliver = out_valid && out_ready.
- col counts accepted pixels 0..LINE_W-1 and wraps to 0 after LINE_W-1.
- act_mode and act_thresh load from cfg_mode and cfg_thresh on an accept with col==0. Changes at other times take effect at the next line start.
- Point modes (00/01/11): on accept, register the output next edge (latency 1 cycle):
  - out_valid=1, out_eol=(col==LINE_W-1).
  - 00: out=pix.
  - 01: out=(2^PIX_W-1)-pix.
  - 11: out = pix>=act_thresh ? all-ones : 0.
- Filter mode (10), with kernel f(a,b,c) = (a + 2b + c + 2) >> 2:
  - Compute in PIX_W+2 bits; the result always fits PIX_W, so no saturation is needed.
  - Accept at col==0: p_prev<=pix, p_cur<=pix (left-edge replication); no output.
  - Accept at col>0: output f(p_prev,p_cur,pix) for column col-1 with eol=0; then p_prev<=p_cur, p_cur<=pix.
  - If col==LINE_W-1, go to FLUSH.
  - FLUSH: in_ready=0. When !out_valid||out_ready, output f(p_prev,p_cur,p_cur) with eol=1 (right-edge replication), then return to RUN.
- Output register holds out_pixel and out_eol stable while out_valid && !out_ready. On deliver with no new load, out_valid falls next cycle.
- pix_count increments by 1 on every deliver; it wraps silently.
- Simultaneous deliver and accept in the same cycle is legal: output reloads with no bubble, giving full throughput.
- Filter mode costs one dead input cycle per line, caused by FLUSH.
- Reset asserted mid-FLUSH or mid-line: returns to the reset state; the partial line is discarded.
- cfg_mode is not sampled while col!=0.

Decomposition:
- Package pix_engine_pkg holds:
  - Mode localparams MODE_BYPASS=2'b00, MODE_INVERT=2'b01, MODE_FILTER=2'b10, MODE_THRESH=2'b11.
  - State encoding ST_RUN and ST_FLUSH.
  - The kernel function f.
- No sub-module required. Optionally split a combinational pix_point_op for modes 00/01/11.

Test Plan (PIX_W=8, LINE_W=4, out_ready=1 unless stated):
1. Bypass: line 0A,14,1E,28 -> out 0A,14,1E,28, each one cycle after accept; eol only on 28; pix_count=4.
2. Invert: 00,3C,FF,80 -> FF,C3,00,7F.
3. Filter: 08,10,18,C8 -> 0A,10,42,9C, with eol on 9C.
   - in_ready low exactly one cycle (FLUSH) after C8 is accepted.
4. Threshold with cfg_thresh=80: 7F,80,81,00 -> 00,FF,FF,00.
5. Backpressure: drop out_ready for 5 cycles mid-line.
   - out_pixel and out_eol stay stable and in_ready=0.
   - No pixel is lost or duplicated.
   - pix_count increments only on delivers.
6. Mode change and reset:
   - cfg_mode 00->01 after col 2 accepted: the rest of that line is bypassed; the next line is inverted.
   - resetn pulsed low during FLUSH: all outputs 0, col=0, and the next line processes correctly.
